// File: rtl/effect_limiter.sv
// Output-stage peak limiter: two-stage gain multiply with attack/hold/release
// gain smoothing and a final hard clamp to the selected threshold.
module effect_limiter #(
   parameter int unsigned ATTACK_STEP  = 512,
   parameter int unsigned RELEASE_STEP = 8,
   parameter int unsigned HOLD_SAMPLES = 480,
   parameter int unsigned GAIN_MIN     = 4096
) (
   input  logic               i_clk,
   input  logic               i_rst,
   input  logic               i_valid,
   input  logic               i_enable,
   input  logic [2:0]         i_level_threshold,
   input  logic signed [15:0] i_data,
   output logic signed [15:0] o_data,
   output logic               o_valid,
   output logic               o_limiting
);

   localparam int unsigned     HOLD_W    = $clog2(HOLD_SAMPLES + 1);
   localparam logic [16:0]     UNITY     = 17'd32768;
   localparam logic [16:0]     ATK       = 17'(ATTACK_STEP);
   localparam logic [16:0]     REL       = 17'(RELEASE_STEP);
   localparam logic [16:0]     GMIN      = 17'(GAIN_MIN);
   localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(HOLD_SAMPLES);

   // stage 1 registers
   logic               s1_valid;
   logic signed [15:0] x_q;
   logic               en_q;
   logic [15:0]        thr_q;
   logic signed [32:0] p_q;

   // gain state
   logic [16:0]        gain_q;
   logic [HOLD_W-1:0]  hold_q;

   // stage 2 combinational
   logic signed [17:0] y;
   logic signed [17:0] thr_s;
   logic [16:0]        a;
   logic signed [15:0] y_clamp;
   logic               over;
   logic [16:0]        gain_next;
   logic [HOLD_W-1:0]  hold_next;

   always_comb begin
      y     = 18'(p_q >>> 15);
      a     = 17'(y[17] ? -y : y);
      thr_s = $signed({2'b00, thr_q});
      over  = (a > {1'b0, thr_q});

      if (y > thr_s)
         y_clamp = thr_q;
      else if (y < -thr_s)
         y_clamp = 16'(-thr_s);
      else
         y_clamp = 16'(y);

      gain_next = gain_q;
      hold_next = hold_q;
      if (!en_q) begin
         gain_next = UNITY;
         hold_next = '0;
      end else if (over) begin
         gain_next = (gain_q >= GMIN + ATK) ? gain_q - ATK : GMIN;
         hold_next = HOLD_LOAD;
      end else if (hold_q != '0) begin
         hold_next = hold_q - HOLD_W'(1);
      end else begin
         gain_next = (gain_q > UNITY - REL) ? UNITY : gain_q + REL;
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         s1_valid   <= 1'b0;
         x_q        <= '0;
         en_q       <= 1'b0;
         thr_q      <= '0;
         p_q        <= '0;
         gain_q     <= UNITY;
         hold_q     <= '0;
         o_data     <= '0;
         o_valid    <= 1'b0;
         o_limiting <= 1'b0;
      end else begin
         s1_valid <= i_valid;
         o_valid  <= s1_valid;
         // stage 1 samples the gain as registered at this edge, so a
         // back-to-back sample does not see the update made in parallel
         if (i_valid) begin
            x_q   <= i_data;
            en_q  <= i_enable;
            thr_q <= {1'b0, i_level_threshold, 12'hFFF};
            p_q   <= 33'(i_data) * 33'($signed({1'b0, gain_q}));
         end
         if (s1_valid) begin
            o_data     <= en_q ? y_clamp : x_q;
            gain_q     <= gain_next;
            hold_q     <= hold_next;
            o_limiting <= (gain_next < UNITY);
         end
      end
   end

endmodule
